// File: rtl/apu_issue_queue.sv
// APU issue queue: requests are accepted and issued in order, completed out of order by tag,
// and their results go back to the core in acceptance order.
module apu_issue_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned NUM_OPS = 3,
    parameter int unsigned OP_W    = 6,
    parameter int unsigned FLAGS_W = 15,
    localparam int unsigned TAG_W  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  apu_req,
    output logic                  apu_gnt,
    input  logic [NUM_OPS*32-1:0] apu_operands_i,
    input  logic [OP_W-1:0]       apu_op,
    input  logic [FLAGS_W-1:0]    apu_flags_i,
    output logic                  apu_rvalid,
    output logic [31:0]           apu_result,
    output logic [4:0]            apu_flags_o,
    output logic                  issue_valid_o,
    input  logic                  issue_ready_i,
    output logic [NUM_OPS*32-1:0] issue_operands_o,
    output logic [OP_W-1:0]       issue_op_o,
    output logic [FLAGS_W-1:0]    issue_flags_o,
    output logic [TAG_W-1:0]      issue_tag_o,
    input  logic                  cmpl_valid_i,
    input  logic [TAG_W-1:0]      cmpl_tag_i,
    input  logic [31:0]           cmpl_result_i,
    output logic [TAG_W:0]        occupancy_o,
    output logic                  core_halt_o,
    output logic                  protocol_err_o
);

    typedef enum logic [1:0] {S_FREE, S_QUEUED, S_ISSUED, S_DONE} slot_state_t;

    localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);

    slot_state_t           state       [DEPTH];
    logic [NUM_OPS*32-1:0] slot_ops    [DEPTH];
    logic [OP_W-1:0]       slot_op     [DEPTH];
    logic [FLAGS_W-1:0]    slot_flags  [DEPTH];
    logic [31:0]           slot_result [DEPTH];

    logic [TAG_W-1:0] wr_ptr;
    logic [TAG_W-1:0] iss_ptr;
    logic [TAG_W-1:0] rd_ptr;
    logic [TAG_W:0]   occ;
    logic             accept;
    logic             issue_fire;
    logic             cmpl_ok;
    logic             retire;

    // Each event needs a distinct slot state, so all four can target different slots in one cycle.
    always_comb begin
        apu_gnt       = !reset && (occ < FULL_CNT);
        accept        = apu_req && apu_gnt;
        issue_valid_o = (state[iss_ptr] == S_QUEUED);
        issue_fire    = issue_valid_o && issue_ready_i;
        cmpl_ok       = cmpl_valid_i && (state[cmpl_tag_i] == S_ISSUED);
        retire        = (state[rd_ptr] == S_DONE);
    end

    assign issue_operands_o = slot_ops[iss_ptr];
    assign issue_op_o       = slot_op[iss_ptr];
    assign issue_flags_o    = slot_flags[iss_ptr];
    assign issue_tag_o      = iss_ptr;
    assign occupancy_o      = occ;
    assign core_halt_o      = (occ == FULL_CNT);
    assign apu_flags_o      = '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= '{default: S_FREE};
            wr_ptr         <= '0;
            iss_ptr        <= '0;
            rd_ptr         <= '0;
            occ            <= '0;
            apu_rvalid     <= 1'b0;
            apu_result     <= '0;
            protocol_err_o <= 1'b0;
        end else begin
            if (accept) begin
                state[wr_ptr] <= S_QUEUED;
                wr_ptr        <= wr_ptr + PTR_ONE;
            end
            if (issue_fire) begin
                state[iss_ptr] <= S_ISSUED;
                iss_ptr        <= iss_ptr + PTR_ONE;
            end
            if (cmpl_ok) begin
                state[cmpl_tag_i] <= S_DONE;
            end else if (cmpl_valid_i) begin
                protocol_err_o <= 1'b1;
            end
            if (retire) begin
                state[rd_ptr] <= S_FREE;
                rd_ptr        <= rd_ptr + PTR_ONE;
                apu_result    <= slot_result[rd_ptr];
            end
            apu_rvalid <= retire;
            case ({accept, retire})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Payload and result storage need no reset: slot state alone decides what is live.
    always_ff @(posedge clk) begin
        if (accept) begin
            slot_ops[wr_ptr]   <= apu_operands_i;
            slot_op[wr_ptr]    <= apu_op;
            slot_flags[wr_ptr] <= apu_flags_i;
        end
        if (cmpl_ok) begin
            slot_result[cmpl_tag_i] <= cmpl_result_i;
        end
    end

endmodule

// File: tb/tb_apu_issue_queue.sv
// Bench for apu_issue_queue: directed DEPTH=4 sequences on one instance and a
// randomized DEPTH=8 run against an in-order instruction-list model on another.
module tb_apu_issue_queue;

    localparam int NRAND = 1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DEPTH=4 instance
    logic        a_req, a_gnt, a_rvalid, a_iv, a_ir, a_cv, a_halt, a_err;
    logic [95:0] a_ops, a_iops;
    logic [5:0]  a_op, a_iop;
    logic [14:0] a_flags, a_iflags;
    logic [31:0] a_result, a_cres;
    logic [4:0]  a_flags_o;
    logic [1:0]  a_itag, a_ctag;
    logic [2:0]  a_occ;

    apu_issue_queue #(.DEPTH(4), .NUM_OPS(3), .OP_W(6), .FLAGS_W(15)) dut_a (
        .clk(clk), .reset(reset), .apu_req(a_req), .apu_gnt(a_gnt),
        .apu_operands_i(a_ops), .apu_op(a_op), .apu_flags_i(a_flags),
        .apu_rvalid(a_rvalid), .apu_result(a_result), .apu_flags_o(a_flags_o),
        .issue_valid_o(a_iv), .issue_ready_i(a_ir), .issue_operands_o(a_iops),
        .issue_op_o(a_iop), .issue_flags_o(a_iflags), .issue_tag_o(a_itag),
        .cmpl_valid_i(a_cv), .cmpl_tag_i(a_ctag), .cmpl_result_i(a_cres),
        .occupancy_o(a_occ), .core_halt_o(a_halt), .protocol_err_o(a_err)
    );

    // DEPTH=8 instance
    logic        b_req, b_gnt, b_rvalid, b_iv, b_ir, b_cv, b_halt, b_err;
    logic [95:0] b_ops, b_iops;
    logic [5:0]  b_op, b_iop;
    logic [14:0] b_flags, b_iflags;
    logic [31:0] b_result, b_cres;
    logic [4:0]  b_flags_o;
    logic [2:0]  b_itag, b_ctag;
    logic [3:0]  b_occ;

    apu_issue_queue #(.DEPTH(8), .NUM_OPS(3), .OP_W(6), .FLAGS_W(15)) dut_b (
        .clk(clk), .reset(reset), .apu_req(b_req), .apu_gnt(b_gnt),
        .apu_operands_i(b_ops), .apu_op(b_op), .apu_flags_i(b_flags),
        .apu_rvalid(b_rvalid), .apu_result(b_result), .apu_flags_o(b_flags_o),
        .issue_valid_o(b_iv), .issue_ready_i(b_ir), .issue_operands_o(b_iops),
        .issue_op_o(b_iop), .issue_flags_o(b_iflags), .issue_tag_o(b_itag),
        .cmpl_valid_i(b_cv), .cmpl_tag_i(b_ctag), .cmpl_result_i(b_cres),
        .occupancy_o(b_occ), .core_halt_o(b_halt), .protocol_err_o(b_err)
    );

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Results returned by the DEPTH=4 instance, with the cycle they appeared in
    logic [31:0] a_got[$];
    int          a_got_cyc[$];
    always @(negedge clk) begin
        if (a_rvalid === 1'b1) begin
            a_got.push_back(a_result);
            a_got_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a_req = 1'b0; a_ops = '0; a_op = '0; a_flags = '0; a_ir = 1'b0;
        a_cv = 1'b0; a_ctag = '0; a_cres = '0;
        b_req = 1'b0; b_ops = '0; b_op = '0; b_flags = '0; b_ir = 1'b0;
        b_cv = 1'b0; b_ctag = '0; b_cres = '0;
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic       req;
        logic [5:0] op;
        logic       ir;
        logic       gnt;
        logic       iv;
        logic [1:0] itag;
        logic [5:0] iop;
        logic [2:0] occ;
        logic       halt;
    } vec_t;

    vec_t tbl[10];
    int   order[4];
    int   c0;

    // Random-run model: instruction i carries tag i % 8 and retires i-th
    int          n_acc, n_iss, n_ret, occ_m, bud, k, idx;
    logic        exp_rv, exp_iv;
    logic [31:0] m_res  [NRAND];
    logic [95:0] m_ops  [NRAND];
    logic [5:0]  m_op   [NRAND];
    logic [14:0] m_flg  [NRAND];
    bit          m_done [NRAND];
    int          m_ccyc [NRAND];
    int          pool[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            req   op     ir    gnt   iv    itag   iop    occ   halt
        tbl[0] = '{1'b1, 6'd1, 1'b0, 1'b1, 1'b0, 2'd0, 6'd0, 3'd0, 1'b0};
        tbl[1] = '{1'b1, 6'd2, 1'b0, 1'b1, 1'b1, 2'd0, 6'd1, 3'd1, 1'b0};
        tbl[2] = '{1'b1, 6'd3, 1'b0, 1'b1, 1'b1, 2'd0, 6'd1, 3'd2, 1'b0};
        tbl[3] = '{1'b1, 6'd4, 1'b0, 1'b1, 1'b1, 2'd0, 6'd1, 3'd3, 1'b0};
        tbl[4] = '{1'b1, 6'd5, 1'b0, 1'b0, 1'b1, 2'd0, 6'd1, 3'd4, 1'b1};
        tbl[5] = '{1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 2'd0, 6'd1, 3'd4, 1'b1};
        tbl[6] = '{1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 2'd1, 6'd2, 3'd4, 1'b1};
        tbl[7] = '{1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 2'd2, 6'd3, 3'd4, 1'b1};
        tbl[8] = '{1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 2'd3, 6'd4, 3'd4, 1'b1};
        tbl[9] = '{1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, 3'd4, 1'b1};
        order[0] = 2; order[1] = 0; order[2] = 3; order[3] = 1;

        do_reset();
        #1;
        check("rst_rvalid", 96'(a_rvalid), 96'(1'b0));
        check("rst_result", 96'(a_result), 96'(32'h0));
        check("rst_issue_valid", 96'(a_iv), 96'(1'b0));
        check("rst_occ", 96'(a_occ), 96'(3'd0));
        check("rst_halt", 96'(a_halt), 96'(1'b0));
        check("rst_err", 96'(a_err), 96'(1'b0));
        check("rst_gnt", 96'(a_gnt), 96'(1'b1));
        check("rst_flags_o", 96'(a_flags_o), 96'(5'd0));

        // Fill to full, then issue all four in order
        for (int i = 0; i < 10; i++) begin
            a_req = tbl[i].req;
            a_op  = tbl[i].op;
            a_ops = {$urandom, $urandom, $urandom};
            a_ir  = tbl[i].ir;
            #1;
            check("t1_gnt", 96'(a_gnt), 96'(tbl[i].gnt));
            check("t1_issue_valid", 96'(a_iv), 96'(tbl[i].iv));
            check("t1_occ", 96'(a_occ), 96'(tbl[i].occ));
            check("t1_halt", 96'(a_halt), 96'(tbl[i].halt));
            if (tbl[i].iv) begin
                check("t1_issue_tag", 96'(a_itag), 96'(tbl[i].itag));
                check("t1_issue_op", 96'(a_iop), 96'(tbl[i].iop));
            end
            tick();
        end
        a_req = 1'b0;
        a_ir  = 1'b0;

        // Out-of-order completion 2,0,3,1 must return results in order
        a_got.delete();
        a_got_cyc.delete();
        c0 = 0;
        for (int i = 0; i < 4; i++) begin
            a_cv   = 1'b1;
            a_ctag = 2'(order[i]);
            a_cres = 32'hA0 + 32'(order[i]);
            if (order[i] == 0) c0 = cyc;
            tick();
        end
        a_cv = 1'b0;
        repeat (6) tick();
        check("t2_count", 96'(a_got.size()), 96'(4));
        if (a_got.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t2_result", 96'(a_got[i]), 96'(32'hA0 + 32'(i)));
            check("t2_latency", 96'(a_got_cyc[0]), 96'(c0 + 2));
        end
        check("t2_occ", 96'(a_occ), 96'(3'd0));
        check("t2_err", 96'(a_err), 96'(1'b0));

        // Full queue: retire of tag 0 does not grant in the same cycle
        a_got.delete();
        for (int i = 0; i < 4; i++) begin
            a_req = 1'b1;
            a_op  = 6'(16 + i);
            a_ir  = 1'b1;
            tick();
        end
        a_req = 1'b0;
        tick();
        a_ir   = 1'b0;
        a_cv   = 1'b1;
        a_ctag = 2'd0;
        a_cres = 32'hB0;
        a_req  = 1'b1;
        a_op   = 6'h20;
        tick();
        a_cv = 1'b0;
        #1;
        check("t3_gnt_retire_cycle", 96'(a_gnt), 96'(1'b0));
        check("t3_halt", 96'(a_halt), 96'(1'b1));
        tick();
        #1;
        check("t3_gnt_next_cycle", 96'(a_gnt), 96'(1'b1));
        tick();
        a_req = 1'b0;
        a_ir  = 1'b1;
        #1;
        check("t3_wrap_valid", 96'(a_iv), 96'(1'b1));
        check("t3_wrap_tag", 96'(a_itag), 96'(2'd0));
        check("t3_wrap_op", 96'(a_iop), 96'(6'h20));
        check("t3_wrap_occ", 96'(a_occ), 96'(3'd4));
        tick();
        a_ir = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            a_cv   = 1'b1;
            a_ctag = 2'(i % 4);
            a_cres = 32'hB0 + 32'(i);
            tick();
        end
        a_cv = 1'b0;
        repeat (6) tick();
        check("t3_count", 96'(a_got.size()), 96'(5));
        if (a_got.size() == 5) begin
            for (int i = 0; i < 5; i++) check("t3_result", 96'(a_got[i]), 96'(32'hB0 + 32'(i)));
        end

        // Completion on a queued tag is ignored and flagged
        do_reset();
        a_got.delete();
        for (int i = 0; i < 4; i++) begin
            a_req = 1'b1;
            a_op  = 6'(32 + i);
            tick();
        end
        a_req  = 1'b0;
        a_cv   = 1'b1;
        a_ctag = 2'd3;
        a_cres = 32'h55;
        tick();
        a_cv = 1'b0;
        #1;
        check("t4_err_set", 96'(a_err), 96'(1'b1));
        a_ir = 1'b1;
        repeat (4) tick();
        a_ir = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_cv   = 1'b1;
            a_ctag = 2'((i + 3) % 4);
            a_cres = 32'hC0 + 32'((i + 3) % 4);
            tick();
        end
        a_cv = 1'b0;
        repeat (6) tick();
        check("t4_count", 96'(a_got.size()), 96'(4));
        if (a_got.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t4_result", 96'(a_got[i]), 96'(32'hC0 + 32'(i)));
        end
        check("t4_err_sticky", 96'(a_err), 96'(1'b1));

        // Reset with three issued entries and a completion in the reset cycle
        for (int i = 0; i < 3; i++) begin
            a_req = 1'b1;
            a_op  = 6'(48 + i);
            a_ir  = 1'b1;
            tick();
        end
        a_req = 1'b0;
        tick();
        a_ir = 1'b0;
        a_got.delete();
        reset  = 1'b1;
        a_cv   = 1'b1;
        a_ctag = 2'd0;
        a_cres = 32'hDD;
        a_req  = 1'b1;
        tick();
        reset = 1'b0;
        a_cv  = 1'b0;
        a_req = 1'b0;
        #1;
        check("t5_occ", 96'(a_occ), 96'(3'd0));
        check("t5_rvalid", 96'(a_rvalid), 96'(1'b0));
        check("t5_err", 96'(a_err), 96'(1'b0));
        check("t5_result", 96'(a_result), 96'(32'h0));
        check("t5_issue_valid", 96'(a_iv), 96'(1'b0));
        check("t5_gnt", 96'(a_gnt), 96'(1'b1));
        repeat (6) tick();
        check("t5_no_stale", 96'(a_got.size()), 96'(0));

        // Randomized streams on the DEPTH=8 instance
        do_reset();
        n_acc = 0; n_iss = 0; n_ret = 0; bud = 0;
        for (int i = 0; i < NRAND; i++) m_done[i] = 1'b0;
        while (n_ret < NRAND && bud < 30000) begin
            b_req   = (n_acc < NRAND) && ($urandom_range(3) != 0);
            b_op    = 6'($urandom);
            b_ops   = {$urandom, $urandom, $urandom};
            b_flags = 15'($urandom);
            b_ir    = ($urandom_range(9) < 7);
            b_cv    = 1'b0;
            if (pool.size() > 0 && $urandom_range(9) < 6) begin
                k = $urandom_range(pool.size() - 1);
                idx = pool[k];
                pool.delete(k);
                b_cv         = 1'b1;
                b_ctag       = 3'(idx % 8);
                b_cres       = $urandom;
                m_res[idx]   = b_cres;
                m_done[idx]  = 1'b1;
                m_ccyc[idx]  = cyc;
            end
            #1;
            exp_rv = (n_ret < n_acc) && m_done[n_ret] && (m_ccyc[n_ret] + 2 <= cyc);
            check("rnd_rvalid", 96'(b_rvalid), 96'(exp_rv));
            if (b_rvalid && n_ret < n_acc) begin
                check("rnd_result", 96'(b_result), 96'(m_res[n_ret]));
                n_ret++;
            end
            occ_m = n_acc - n_ret;
            check("rnd_occ", 96'(b_occ), 96'(occ_m));
            check("rnd_gnt", 96'(b_gnt), 96'(occ_m < 8));
            check("rnd_halt", 96'(b_halt), 96'(occ_m == 8));
            exp_iv = (n_iss < n_acc);
            check("rnd_issue_valid", 96'(b_iv), 96'(exp_iv));
            if (exp_iv) begin
                check("rnd_issue_tag", 96'(b_itag), 96'(n_iss % 8));
                check("rnd_issue_op", 96'(b_iop), 96'(m_op[n_iss]));
                check("rnd_issue_ops", b_iops, m_ops[n_iss]);
                check("rnd_issue_flags", 96'(b_iflags), 96'(m_flg[n_iss]));
            end
            if (b_req && occ_m < 8) begin
                m_op[n_acc]  = b_op;
                m_ops[n_acc] = b_ops;
                m_flg[n_acc] = b_flags;
                n_acc++;
            end
            if (exp_iv && b_ir) begin
                pool.push_back(n_iss);
                n_iss++;
            end
            tick();
            bud++;
        end
        b_req = 1'b0;
        b_ir  = 1'b0;
        b_cv  = 1'b0;
        check("rnd_all_retired", 96'(n_ret), 96'(NRAND));
        check("rnd_all_accepted", 96'(n_acc), 96'(NRAND));
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rnd_no_extra_rvalid", 96'(b_rvalid), 96'(1'b0));
            tick();
        end
        check("rnd_final_occ", 96'(b_occ), 96'(4'd0));
        check("rnd_no_err", 96'(b_err), 96'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apu_issue_queue.md
# apu_issue_queue

Parametrised APU front-end between the CV32E40P APU port and the vector decoder/execution pipeline. It buffers up to DEPTH accepted instructions, issues them in order through a valid/ready port, and accepts completions out of order by tag. Results return to the core strictly in acceptance order. It replaces the single-outstanding, combinational request/result path of the current accelerator top so that VLSU and arithmetic instructions can overlap.

## Interface
Parameters:
- DEPTH, 4, queue slots / max outstanding instructions; power of two, >= 2
- NUM_OPS, 3, APU operands per request, 32 b each
- OP_W, 6, apu_op width
- FLAGS_W, 15, apu_flags_i width
- TAG_W, $clog2(DEPTH), tag width (derived, not overridden)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- apu_req  in  1  core request
- apu_gnt  out  1  request accepted this cycle (combinational)
- apu_operands_i  in  NUM_OPS x 32  request operands
- apu_op  in  OP_W  request opcode
- apu_flags_i  in  FLAGS_W  request flags
- apu_rvalid  out  1  result valid, one-cycle pulse per instruction
- apu_result  out  32  result, valid with apu_rvalid
- apu_flags_o  out  5  tied to 0
- issue_valid_o  out  1  oldest unissued entry available
- issue_ready_i  in  1  decoder takes entry
- issue_operands_o  out  NUM_OPS x 32  entry operands
- issue_op_o  out  OP_W  entry opcode
- issue_flags_o  out  FLAGS_W  entry flags
- issue_tag_o  out  TAG_W  entry slot index
- cmpl_valid_i  in  1  completion strobe
- cmpl_tag_i  in  TAG_W  completing slot
- cmpl_result_i  in  32  result for that slot
- occupancy_o  out  TAG_W+1  slots held (accepted, not retired)
- core_halt_o  out  1  high while occupancy_o == DEPTH
- protocol_err_o  out  1  sticky illegal-completion flag

## Operation
- Ring of DEPTH slots. Each slot holds payload, result, and state: FREE, QUEUED, ISSUED, DONE.
- Three pointers, TAG_W bits, wrapping modulo DEPTH: wr_ptr (next free), iss_ptr (oldest QUEUED), rd_ptr (oldest held).
- Accept:
  - apu_gnt = (occupancy_o < DEPTH).
  - On apu_req & apu_gnt, the payload is written to slot wr_ptr, the slot goes QUEUED, and wr_ptr increments.
  - Tag = slot index.
- Issue:
  - issue_valid_o = (slot iss_ptr is QUEUED); issue_* are driven from that slot.
  - On issue_valid_o & issue_ready_i, the slot goes ISSUED and iss_ptr increments.
  - Strictly in order.
- Complete:
  - On cmpl_valid_i, if slot cmpl_tag_i is ISSUED, cmpl_result_i is stored and the slot goes DONE.
  - Otherwise the completion is ignored and protocol_err_o sets; it is cleared only by reset.
- Retire:
  - When slot rd_ptr is DONE, it goes FREE, rd_ptr increments, and apu_result/apu_rvalid are registered.
  - At most one retire per cycle.
- occupancy_o: +1 on accept, -1 on retire, unchanged when both occur in the same cycle.
- Simultaneous events in one cycle (accept, issue, complete, retire) are all legal on distinct slots and all take effect.

## Timing
- Reset values:
  - apu_rvalid = 0, apu_result = 0, issue_valid_o = 0, occupancy_o = 0, core_halt_o = 0, protocol_err_o = 0.
  - apu_gnt = 1 once reset is low.
  - All pointers are 0 and all slots FREE.
- Reset mid-operation discards all entries. Completions and requests sampled in a reset cycle are ignored. No apu_rvalid is produced for discarded entries.
- Accept to issue: an entry granted in cycle N is presented (issue_valid_o) no earlier than N+1. There is no same-cycle bypass.
- Completion to result: cmpl_valid_i in cycle N on the rd_ptr slot gives apu_rvalid high in cycle N+2. The DONE state is visible in N+1, and the retire register is loaded at the end of N+1.
- Completion for a tag is legal from the cycle after its issue handshake. A completion in the same cycle as that handshake is illegal and sets protocol_err_o.
- Full:
  - apu_gnt uses the current occupancy.
  - A retire in the same cycle does not enable a grant; the freed slot is grantable next cycle.
- Empty:
  - issue_valid_o = 0.
  - issue_* outputs hold the last slot contents; they are don't-care.
- Back-to-back: sustained throughput is 1 accept, 1 issue, and 1 retire per cycle.
- Wrap: pointers wrap from DEPTH-1 to 0. Full versus empty is resolved by occupancy_o, not by pointer equality.

## Test plan
- Reset, then 4 requests with op=1..4 in consecutive cycles, DEPTH=4:
  - apu_gnt high on all 4 and low on the 5th cycle.
  - core_halt_o=1 and occupancy_o=4.
  - issue_tag_o sequence 0,1,2,3.
- Issue all 4, complete tags in order 2,0,3,1 with results 0xA2,0xA0,0xA3,0xA1:
  - apu_rvalid results in order 0xA0,0xA1,0xA2,0xA3.
  - The first result arrives 2 cycles after the tag-0 completion.
- Full queue with retire of tag 0 in cycle N and apu_req held high:
  - apu_gnt=0 in N, apu_gnt=1 in N+1.
  - The new entry receives tag 0 (wrap).
- Completion on a QUEUED (unissued) tag 3 with result 0x55:
  - The completion is ignored and protocol_err_o=1 until reset.
  - The later legal completion of tag 3 is returned normally.
- Reset asserted with 3 entries ISSUED and a completion on the same cycle:
  - Next cycle occupancy_o=0, apu_rvalid=0, protocol_err_o=0.
  - No stale result ever appears.
- Random accept/issue_ready/completion streams of 1000 instructions, DEPTH=8:
  - Results are returned in order.
  - occupancy_o never exceeds 8.
  - Every granted request retires exactly once.
